// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes and FSM state encoding shared by the sequential ALU
package alu_seq_pkg;
    localparam logic [3:0] OP_MOV = 4'h0;
    localparam logic [3:0] OP_NOT = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_SLL = 4'h8;
    localparam logic [3:0] OP_SRL = 4'h9;
    localparam logic [3:0] OP_SRA = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_t;
endpackage

// File: rtl/alu_mul_serial.sv
// alu_mul_serial: shift-add multiplier, one multiplier bit per cycle, WIDTH cycles
// Ports: clk, rst (async high), start (load a/b), a, b, busy, done (product valid this cycle), product (low WIDTH bits)
module alu_mul_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [WIDTH-1:0] ma, mb, acc;
    logic [CW-1:0] cnt;
    // product is the accumulator after this cycle's step, so the final value is usable on the done edge
    assign product = acc + (mb[0] ? ma : '0);
    assign done = busy && cnt == 1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '0;
            mb <= '0;
            acc <= '0;
            cnt <= '0;
            busy <= 1'b0;
        end else if (start) begin
            ma <= a;
            mb <= b;
            acc <= '0;
            cnt <= CW'(WIDTH);
            busy <= 1'b1;
        end else if (busy) begin
            acc <= product;
            ma <= ma << 1;
            mb <= mb >> 1;
            cnt <= cnt - 1;
            busy <= cnt != 1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with registered result/flags, valid/ready handshakes, serial shifts and multiply
// Ports: clk, rst (async high); in_valid/in_ready, alu_op, r2 (A), r3 (B/shift amount);
//        out_valid/out_ready, r1 (result), flags {N,Z,C,V}, illegal (undefined or disabled opcode)
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] r3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r1,
    output logic [3:0]       flags,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);
    state_t state;
    logic [WIDTH-1:0] sh_val, sh_next, c_res, mul_p;
    logic [SW:0] cnt;
    logic [SW-1:0] sh;
    logic [3:0] sh_op;
    logic [WIDTH:0] sum, dif;
    logic accept, is_shift, is_mul, c_c, c_v, c_ill, sh_out, mul_start, mul_busy, mul_done;
    assign sh = r3[SW-1:0];
    assign in_ready = !rst && state == S_IDLE && (!out_valid || out_ready);
    assign accept = in_valid && in_ready;
    assign is_shift = alu_op == OP_SLL || alu_op == OP_SRL || alu_op == OP_SRA;
    assign is_mul = MUL_EN && alu_op == OP_MUL;
    assign mul_start = accept && is_mul;
    assign sh_next = sh_op == OP_SLL ? {sh_val[WIDTH-2:0], 1'b0} :
                     sh_op == OP_SRA ? {sh_val[WIDTH-1], sh_val[WIDTH-1:1]} : {1'b0, sh_val[WIDTH-1:1]};
    assign sh_out = sh_op == OP_SLL ? sh_val[WIDTH-1] : sh_val[0];
    always_comb begin
        sum = {1'b0, r2} + {1'b0, r3};
        dif = {1'b0, r2} - {1'b0, r3};
        c_res = '0;
        c_c = 1'b0;
        c_v = 1'b0;
        c_ill = 1'b0;
        case (alu_op)
            OP_MOV: c_res = r2;
            OP_NOT: c_res = ~r2;
            OP_ADD: begin
                c_res = sum[WIDTH-1:0];
                c_c = sum[WIDTH];
                c_v = r2[WIDTH-1] == r3[WIDTH-1] && sum[WIDTH-1] != r2[WIDTH-1];
            end
            OP_SUB: begin
                c_res = dif[WIDTH-1:0];
                c_c = !dif[WIDTH];
                c_v = r2[WIDTH-1] != r3[WIDTH-1] && dif[WIDTH-1] != r2[WIDTH-1];
            end
            OP_AND: c_res = r2 & r3;
            OP_OR:  c_res = r2 | r3;
            OP_XOR: c_res = r2 ^ r3;
            OP_SLT: c_res = {{(WIDTH-1){1'b0}}, $signed(r2) < $signed(r3)};
            // a shift only lands here with a zero amount, which passes A through
            OP_SLL, OP_SRL, OP_SRA: c_res = r2;
            OP_MUL: c_ill = !MUL_EN;
            default: c_ill = 1'b1;
        endcase
    end
    if (MUL_EN) begin : g_mul
        alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
            .clk(clk), .rst(rst), .start(mul_start), .a(r2), .b(r3),
            .busy(mul_busy), .done(mul_done), .product(mul_p)
        );
    end else begin : g_nomul
        assign mul_busy = 1'b0;
        assign mul_done = 1'b0;
        assign mul_p = '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            out_valid <= 1'b0;
            r1 <= '0;
            flags <= '0;
            illegal <= 1'b0;
            sh_val <= '0;
            cnt <= '0;
            sh_op <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && is_shift && sh != 0) begin
                        state <= S_SHIFT;
                        sh_val <= r2;
                        cnt <= {1'b0, sh};
                        sh_op <= alu_op;
                        out_valid <= 1'b0;
                    end else if (accept && is_mul) begin
                        state <= S_MUL;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        r1 <= c_res;
                        flags <= {c_res[WIDTH-1], c_res == 0, c_c, c_v};
                        illegal <= c_ill;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    sh_val <= sh_next;
                    cnt <= cnt - 1;
                    if (cnt == 1) begin
                        r1 <= sh_next;
                        flags <= {sh_next[WIDTH-1], sh_next == 0, sh_out, 1'b0};
                        illegal <= 1'b0;
                        out_valid <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        r1 <= mul_p;
                        flags <= {mul_p[WIDTH-1], mul_p == 0, 2'b00};
                        illegal <= 1'b0;
                        out_valid <= 1'b1;
                        state <= S_IDLE;
                    end else if (!mul_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (default build plus a MUL_EN=0 build)
module tb_alu_seq;
    logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0] alu_op = 4'h0;
    logic [31:0] r2 = '0, r3 = '0;
    logic in_ready, out_valid, illegal, b_in_ready, b_out_valid, b_illegal;
    logic [31:0] r1, b_r1;
    logic [3:0] flags, b_flags;
    int n_tests = 0, n_fail = 0;
    int lat;
    logic rdy, ok;

    alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
        .r2(r2), .r3(r3), .out_valid(out_valid), .out_ready(out_ready), .r1(r1),
        .flags(flags), .illegal(illegal)
    );
    alu_seq #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .alu_op(alu_op),
        .r2(r2), .r3(r3), .out_valid(b_out_valid), .out_ready(out_ready), .r1(b_r1),
        .flags(b_flags), .illegal(b_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one op, scramble operands after accept, return cycles from accept edge to out_valid
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int l);
        alu_op = op;
        r2 = a;
        r3 = b;
        in_valid = 1'b1;
        l = 0;
        while (!in_ready && l < 100) begin
            tick();
            l++;
        end
        tick();
        in_valid = 1'b0;
        alu_op = 4'h0;
        r2 = 32'hDEADBEEF;
        r3 = 32'h13579BDF;
        l = 1;
        while (!out_valid && l < 100) begin
            tick();
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int el);
        int l;
        do_op(op, a, b, l);
        check({tag, "_r1"}, r1, er);
        check({tag, "_flags"}, 32'(flags), 32'(ef));
        check({tag, "_lat"}, 32'(l), 32'(el));
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r1", r1, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        run("add", 4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1);
        check("add_illegal", 32'(illegal), 32'd0);
        run("sub", 4'h3, 32'h0000FFFF, 32'hFFFF0000, 32'h0001FFFF, 4'b0000, 1);
        run("add_c", 4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1);
        run("and", 4'h4, 32'hFF00FF00, 32'h00FF00FF, 32'h00000000, 4'b0100, 1);
        run("or", 4'h5, 32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 4'b1000, 1);
        run("slt", 4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000, 1);
        run("sra", 4'hA, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000, 5);
        run("sll", 4'h8, 32'h0000FFFF, 32'h00000010, 32'hFFFF0000, 4'b1000, 17);
        run("srl0", 4'h9, 32'h00001234, 32'h00000020, 32'h00001234, 4'b0000, 1);
        run("srl1", 4'h9, 32'h00000003, 32'h00000001, 32'h00000001, 4'b0010, 2);

        // MUL: new requests during the multiply must be ignored
        alu_op = 4'hB;
        r2 = 32'h0000FFFF;
        r3 = 32'h00010001;
        in_valid = 1'b1;
        tick();
        alu_op = 4'h2;
        r2 = 32'h11111111;
        r3 = 32'h22222222;
        check("mul_dis_valid", 32'(b_out_valid), 32'd1);
        check("mul_dis_illegal", 32'(b_illegal), 32'd1);
        check("mul_dis_r1", b_r1, 32'd0);
        lat = 1;
        rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            rdy |= in_ready;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("mul_r1", r1, 32'hFFFFFFFF);
        check("mul_flags", 32'(flags), 32'b1000);
        check("mul_lat", 32'(lat), 32'd33);
        check("mul_in_ready_low", 32'(rdy), 32'd0);

        // backpressure: result held while out_ready=0
        tick();
        out_ready = 1'b0;
        do_op(4'h2, 32'd5, 32'd3, lat);
        check("bp_r1", r1, 32'd8);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            ok &= r1 == 32'd8 && flags == 4'b0000 && out_valid && !in_ready;
        end
        check("bp_hold", 32'(ok), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            alu_op = 4'h2;
            r2 = 32'(i * 17);
            r3 = 32'h100;
            in_valid = 1'b1;
            tick();
            check($sformatf("stream%0d", i), r1, 32'(i * 17 + 256));
            check($sformatf("stream%0d_v", i), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);

        run("ill", 4'hF, 32'd123, 32'd456, 32'd0, 4'b0100, 1);
        check("ill_flag", 32'(illegal), 32'd1);

        // async reset in the middle of a multiply
        tick();
        alu_op = 4'hB;
        r2 = 32'd3;
        r3 = 32'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_r1", r1, 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("mrst_in_ready_after", 32'(in_ready), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            ok &= !out_valid;
        end
        check("mrst_no_result", 32'(ok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
